decode_stage_p: RTL and testbench

- Parametrised second-generation decode stage for the pipelined core.
- Contains:
  - register file with write-through bypass;
  - branch/jr operand forwarding, selected internally from MEM/WB state rather than external select inputs;
  - load-use and branch-dependence hazard detection with stall generation;
  - registered ID/EX pipeline boundary with bubble insertion and downstream hold;
  - saturating stall-cycle counter.
- Sits between the IF/ID register and the execute stage. The existing control unit drives the ctrl_* inputs.

---
 rtl/decode_stage_p_if.sv | 71 +++++++
 rtl/decode_stage_p.sv | 175 +++++++++++++++++
 tb/tb_decode_stage_p.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_p_if.sv
// Decode-stage bus: IF/ID inputs, MEM/WB snoop inputs, hazard/redirect outputs and the
// registered ID/EX boundary.
interface decode_stage_p_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [31:0]       instruction;
  logic [PC_W-1:0]   pc_plus1;
  logic              ctrl_branch;
  logic              ctrl_bne;
  logic              ctrl_jump;
  logic              ctrl_jr;
  logic              ctrl_jal;
  logic              ctrl_reg_dst;
  logic              ctrl_reg_write;
  logic              ctrl_mem_read;
  logic [CTRL_W-1:0] ctrl_bundle;
  logic              hold_in;

  logic              mem_reg_write;
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_dest;
  logic [DATA_W-1:0] mem_alu_res;

  logic              wb_we;
  logic              wb_jal;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;

  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_target;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_jal;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dest;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [PC_W-1:0]   ex_pc_plus1;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, instruction, pc_plus1, ctrl_branch, ctrl_bne, ctrl_jump, ctrl_jr,
           ctrl_jal, ctrl_reg_dst, ctrl_reg_write, ctrl_mem_read, ctrl_bundle, hold_in,
           mem_reg_write, mem_mem_read, mem_dest, mem_alu_res,
           wb_we, wb_jal, wb_dest, wb_data,
    input  stall, redirect, redirect_target, ex_valid, ex_reg_write, ex_mem_read, ex_jal,
           ex_rs, ex_rt, ex_dest, ex_shamt, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus1,
           ex_ctrl, stall_count
  );

  modport slave (
    input  id_valid, instruction, pc_plus1, ctrl_branch, ctrl_bne, ctrl_jump, ctrl_jr,
           ctrl_jal, ctrl_reg_dst, ctrl_reg_write, ctrl_mem_read, ctrl_bundle, hold_in,
           mem_reg_write, mem_mem_read, mem_dest, mem_alu_res,
           wb_we, wb_jal, wb_dest, wb_data,
    output stall, redirect, redirect_target, ex_valid, ex_reg_write, ex_mem_read, ex_jal,
           ex_rs, ex_rt, ex_dest, ex_shamt, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus1,
           ex_ctrl, stall_count
  );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: register file with WB write-through, branch/jr operand forwarding from MEM,
// hazard detection, ID/EX register with bubble/hold and a saturating stall counter.
module decode_stage_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  decode_stage_p_if.slave dec_io
);
  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] LinkReg = '1;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              jal;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc_plus1;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  logic [DATA_W-1:0] rf_q [NumRegs];
  logic [DATA_W-1:0] rf_d [NumRegs];
  ex_t               ex_q, ex_d, ex_dec;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic [REG_AW-1:0] rs_a, rt_a, rd_a, wr_addr, dest;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   imm_pc;
  logic              wr_en;
  logic [DATA_W-1:0] rs_rf, rt_rf, op_a, op_b;
  logic              mem_fwd_ok, br_or_jr;
  logic              haz_a, haz_b, haz_c, hazard, stall, taken, redirect;
  logic [PC_W-1:0]   target;

  // Field extraction and register-file reads with WB write-through.
  always_comb begin
    rs_a    = REG_AW'(dec_io.instruction[25:21]);
    rt_a    = REG_AW'(dec_io.instruction[20:16]);
    rd_a    = REG_AW'(dec_io.instruction[15:11]);
    imm     = dec_io.instruction[15:0];
    imm_ext = DATA_W'($signed(imm));
    imm_pc  = PC_W'($signed(imm));
    dest    = dec_io.ctrl_jal ? LinkReg : (dec_io.ctrl_reg_dst ? rd_a : rt_a);

    wr_addr = dec_io.wb_jal ? LinkReg : dec_io.wb_dest;
    wr_en   = dec_io.wb_we && (wr_addr != '0);

    rs_rf = rf_q[rs_a];
    if (rs_a == '0) begin
      rs_rf = '0;
    end else if (wr_en && (rs_a == wr_addr)) begin
      rs_rf = dec_io.wb_data;
    end
    rt_rf = rf_q[rt_a];
    if (rt_a == '0) begin
      rt_rf = '0;
    end else if (wr_en && (rt_a == wr_addr)) begin
      rt_rf = dec_io.wb_data;
    end

    // Only non-load ALU results in MEM are ready to feed the branch comparator.
    mem_fwd_ok = dec_io.mem_reg_write && !dec_io.mem_mem_read && (dec_io.mem_dest != '0);
    op_a = (mem_fwd_ok && (dec_io.mem_dest == rs_a)) ? dec_io.mem_alu_res : rs_rf;
    op_b = (mem_fwd_ok && (dec_io.mem_dest == rt_a)) ? dec_io.mem_alu_res : rt_rf;
  end

  // Hazards, stall and redirect.
  always_comb begin
    br_or_jr = dec_io.ctrl_branch || dec_io.ctrl_jr;

    haz_a = dec_io.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) &&
            ((ex_q.dest == rs_a) || (ex_q.dest == rt_a));
    haz_b = dec_io.id_valid && br_or_jr && ex_q.valid && ex_q.reg_write &&
            (ex_q.dest != '0) &&
            ((ex_q.dest == rs_a) || (dec_io.ctrl_branch && (ex_q.dest == rt_a)));
    haz_c = dec_io.id_valid && br_or_jr && dec_io.mem_mem_read && dec_io.mem_reg_write &&
            (dec_io.mem_dest != '0) &&
            ((dec_io.mem_dest == rs_a) || (dec_io.ctrl_branch && (dec_io.mem_dest == rt_a)));
    hazard = haz_a || haz_b || haz_c;
    stall  = dec_io.hold_in || hazard;

    taken    = dec_io.ctrl_branch && ((op_a == op_b) ^ dec_io.ctrl_bne);
    redirect = dec_io.id_valid && !stall &&
               (dec_io.ctrl_jr || dec_io.ctrl_jump || dec_io.ctrl_jal || taken);

    target = '0;
    if (redirect) begin
      if (dec_io.ctrl_jr) begin
        target = op_a[PC_W-1:0];
      end else if (dec_io.ctrl_jump || dec_io.ctrl_jal) begin
        target = dec_io.instruction[PC_W-1:0];
      end else begin
        target = dec_io.pc_plus1 + imm_pc;
      end
    end
  end

  // Next state: register file, ID/EX boundary and stall counter.
  always_comb begin
    rf_d = rf_q;
    if (wr_en) begin
      rf_d[wr_addr] = dec_io.wb_data;
    end

    ex_dec           = '0;
    ex_dec.valid     = 1'b1;
    ex_dec.reg_write = dec_io.ctrl_reg_write;
    ex_dec.mem_read  = dec_io.ctrl_mem_read;
    ex_dec.jal       = dec_io.ctrl_jal;
    ex_dec.rs        = rs_a;
    ex_dec.rt        = rt_a;
    ex_dec.dest      = dest;
    ex_dec.shamt     = dec_io.instruction[10:6];
    ex_dec.rs_data   = rs_rf;
    ex_dec.rt_data   = rt_rf;
    ex_dec.imm       = imm_ext;
    ex_dec.pc_plus1  = dec_io.pc_plus1;
    ex_dec.ctrl      = dec_io.ctrl_bundle;

    ex_d = ex_q;
    if (!dec_io.hold_in) begin
      ex_d = (stall || !dec_io.id_valid) ? '0 : ex_dec;
    end

    stall_count_d = stall_count_q;
    if (hazard && !dec_io.hold_in && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      rf_q          <= rf_d;
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign dec_io.stall           = stall;
  assign dec_io.redirect        = redirect;
  assign dec_io.redirect_target = target;
  assign dec_io.ex_valid        = ex_q.valid;
  assign dec_io.ex_reg_write    = ex_q.reg_write;
  assign dec_io.ex_mem_read     = ex_q.mem_read;
  assign dec_io.ex_jal          = ex_q.jal;
  assign dec_io.ex_rs           = ex_q.rs;
  assign dec_io.ex_rt           = ex_q.rt;
  assign dec_io.ex_dest         = ex_q.dest;
  assign dec_io.ex_shamt        = ex_q.shamt;
  assign dec_io.ex_rs_data      = ex_q.rs_data;
  assign dec_io.ex_rt_data      = ex_q.rt_data;
  assign dec_io.ex_imm          = ex_q.imm;
  assign dec_io.ex_pc_plus1     = ex_q.pc_plus1;
  assign dec_io.ex_ctrl         = ex_q.ctrl;
  assign dec_io.stall_count     = stall_count_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: directed scenarios plus a randomized run against a
// behavioural model of the decode rules (counter built 4 bits wide to reach saturation).
module tb_decode_stage_p;
  localparam int unsigned DW = 32, PW = 10, AW = 5, CW = 8, NW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nc  = 0;
  int   nf  = 0;

  decode_stage_p_if #(.DATA_W(DW), .PC_W(PW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(NW)) bus ();

  decode_stage_p #(.DATA_W(DW), .PC_W(PW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk    (clk),
    .rst    (rst),
    .dec_io (bus)
  );

  always #5 clk = ~clk;

  // Model state for the randomized run.
  logic [31:0] mrf [32];
  logic        m_v, m_rw, m_mr, m_jal;
  logic [4:0]  m_rs, m_rt, m_dst, m_sh;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [9:0]  m_pc;
  logic [7:0]  m_ctl;
  logic [3:0]  m_cnt;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    bus.ctrl_branch = 1'b0; bus.ctrl_bne = 1'b0; bus.ctrl_jump = 1'b0; bus.ctrl_jr = 1'b0;
    bus.ctrl_jal = 1'b0; bus.ctrl_reg_dst = 1'b0; bus.ctrl_reg_write = 1'b0;
    bus.ctrl_mem_read = 1'b0; bus.ctrl_bundle = '0;
  endtask

  task automatic idle();
    clr_ctrl();
    bus.id_valid = 1'b0; bus.instruction = '0; bus.pc_plus1 = '0; bus.hold_in = 1'b0;
    bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0; bus.mem_dest = '0; bus.mem_alu_res = '0;
    bus.wb_we = 1'b0; bus.wb_jal = 1'b0; bus.wb_dest = '0; bus.wb_data = '0;
  endtask

  task automatic dec_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clr_ctrl();
    bus.id_valid = 1'b1; bus.instruction = {6'd0, rs, rt, rd, 5'd0, 6'h20};
    bus.ctrl_reg_dst = 1'b1; bus.ctrl_reg_write = 1'b1; bus.ctrl_bundle = 8'h21;
  endtask

  task automatic dec_lw(input logic [4:0] rs, input logic [4:0] rt);
    clr_ctrl();
    bus.id_valid = 1'b1; bus.instruction = {6'h23, rs, rt, 16'd0};
    bus.ctrl_reg_write = 1'b1; bus.ctrl_mem_read = 1'b1; bus.ctrl_bundle = 8'h53;
  endtask

  task automatic dec_br(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                        input logic bne);
    clr_ctrl();
    bus.id_valid = 1'b1; bus.instruction = {(bne ? 6'h05 : 6'h04), rs, rt, imm};
    bus.ctrl_branch = 1'b1; bus.ctrl_bne = bne;
  endtask

  function automatic logic [4:0] pick();
    int r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] val();
    return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    nc++; if (bus.ex_valid !== 1'b0) begin nf++; $display("FAIL rst_ex_valid got %0h want 0", bus.ex_valid); end
    nc++; if (bus.stall_count !== 4'd0) begin nf++; $display("FAIL rst_count got %0h want 0", bus.stall_count); end
    nc++; if (bus.stall !== 1'b0 || bus.redirect !== 1'b0) begin
      nf++; $display("FAIL rst_stall_redirect got %b%b want 00", bus.stall, bus.redirect); end
    nc++; if (bus.ex_ctrl !== 8'd0 || bus.ex_rs_data !== 32'd0) begin
      nf++; $display("FAIL rst_ex_data got %h/%h want 0/0", bus.ex_ctrl, bus.ex_rs_data); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_wb_bypass();
    idle();
    dec_alu(5'd3, 5'd0, 5'd4);
    bus.wb_we = 1'b1; bus.wb_dest = 5'd3; bus.wb_data = 32'h12;
    cyc();
    nc++; if (bus.ex_rs_data !== 32'h12) begin nf++; $display("FAIL wt_rs_data got %h want 12", bus.ex_rs_data); end
    nc++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd4) begin
      nf++; $display("FAIL wt_dest got v%b d%0d want v1 d4", bus.ex_valid, bus.ex_dest); end
    bus.wb_we = 1'b0;
    cyc();
    nc++; if (bus.ex_rs_data !== 32'h12) begin nf++; $display("FAIL rf_store got %h want 12", bus.ex_rs_data); end
    dec_alu(5'd0, 5'd0, 5'd4);
    bus.wb_we = 1'b1; bus.wb_dest = 5'd0; bus.wb_data = 32'h55;
    cyc();
    nc++; if (bus.ex_rs_data !== 32'd0 || bus.ex_rt_data !== 32'd0) begin
      nf++; $display("FAIL r0_bypass got %h/%h want 0/0", bus.ex_rs_data, bus.ex_rt_data); end
    bus.wb_we = 1'b0;
    cyc();
    nc++; if (bus.ex_rs_data !== 32'd0) begin nf++; $display("FAIL r0_read got %h want 0", bus.ex_rs_data); end
  endtask

  task automatic test_load_use();
    idle();
    dec_lw(5'd0, 5'd5);
    cyc();
    dec_alu(5'd5, 5'd1, 5'd6);
    #2;
    nc++; if (bus.stall !== 1'b1) begin nf++; $display("FAIL lu_stall got %b want 1", bus.stall); end
    cyc();
    nc++; if (bus.ex_valid !== 1'b0) begin nf++; $display("FAIL lu_bubble got %b want 0", bus.ex_valid); end
    nc++; if (bus.stall_count !== 4'd1) begin nf++; $display("FAIL lu_count got %0d want 1", bus.stall_count); end
    #2;
    nc++; if (bus.stall !== 1'b0) begin nf++; $display("FAIL lu_release got %b want 0", bus.stall); end
    cyc();
    nc++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd6 || bus.ex_rs !== 5'd5) begin
      nf++; $display("FAIL lu_issue got v%b d%0d rs%0d want v1 d6 rs5", bus.ex_valid, bus.ex_dest, bus.ex_rs); end
  endtask

  task automatic test_branch_wrap();
    idle();
    dec_br(5'd2, 5'd2, 16'd4, 1'b0);
    bus.pc_plus1 = 10'h3FE;
    #2;
    nc++; if (bus.redirect !== 1'b1 || bus.redirect_target !== 10'h002) begin
      nf++; $display("FAIL beq_wrap got r%b t%h want r1 t002", bus.redirect, bus.redirect_target); end
    bus.ctrl_bne = 1'b1;
    #1;
    nc++; if (bus.redirect !== 1'b0 || bus.redirect_target !== 10'h000) begin
      nf++; $display("FAIL bne_not_taken got r%b t%h want r0 t000", bus.redirect, bus.redirect_target); end
    idle();
    cyc();
  endtask

  task automatic test_branch_fwd();
    idle();
    dec_alu(5'd1, 5'd2, 5'd7);
    bus.wb_we = 1'b1; bus.wb_dest = 5'd7; bus.wb_data = 32'h99;
    cyc();
    bus.wb_we = 1'b0;
    dec_br(5'd7, 5'd0, 16'd8, 1'b0);
    bus.pc_plus1 = 10'h010;
    #2;
    nc++; if (bus.stall !== 1'b1 || bus.redirect !== 1'b0) begin
      nf++; $display("FAIL brex_stall got s%b r%b want s1 r0", bus.stall, bus.redirect); end
    cyc();
    nc++; if (bus.ex_valid !== 1'b0 || bus.stall_count !== 4'd2) begin
      nf++; $display("FAIL brex_bubble got v%b c%0d want v0 c2", bus.ex_valid, bus.stall_count); end
    bus.mem_reg_write = 1'b1; bus.mem_dest = 5'd7; bus.mem_alu_res = 32'd0;
    #2;
    nc++; if (bus.stall !== 1'b0 || bus.redirect !== 1'b1 || bus.redirect_target !== 10'h018) begin
      nf++; $display("FAIL brmem_fwd got s%b r%b t%h want s0 r1 t018", bus.stall, bus.redirect,
                     bus.redirect_target); end
    bus.mem_reg_write = 1'b0;
    #1;
    nc++; if (bus.redirect !== 1'b0) begin nf++; $display("FAIL br_rf_value got r%b want 0", bus.redirect); end
    idle();
    cyc();
  endtask

  task automatic test_jal_jr();
    idle();
    bus.id_valid = 1'b1; bus.ctrl_jal = 1'b1; bus.instruction = 32'h0C00_0123;
    bus.wb_we = 1'b1; bus.wb_jal = 1'b1; bus.wb_dest = 5'd5; bus.wb_data = 32'h44;
    #2;
    nc++; if (bus.redirect !== 1'b1 || bus.redirect_target !== 10'h123) begin
      nf++; $display("FAIL jal_target got r%b t%h want r1 t123", bus.redirect, bus.redirect_target); end
    cyc();
    nc++; if (bus.ex_jal !== 1'b1 || bus.ex_dest !== 5'd31) begin
      nf++; $display("FAIL jal_dest got j%b d%0d want j1 d31", bus.ex_jal, bus.ex_dest); end
    idle();
    cyc();
    clr_ctrl();
    bus.id_valid = 1'b1; bus.ctrl_jr = 1'b1; bus.instruction = {6'd0, 5'd31, 15'd0, 6'h08};
    #2;
    nc++; if (bus.redirect !== 1'b1 || bus.redirect_target !== 10'h044) begin
      nf++; $display("FAIL jr_target got r%b t%h want r1 t044", bus.redirect, bus.redirect_target); end
    idle();
    cyc();
  endtask

  task automatic test_hold();
    idle();
    dec_lw(5'd0, 5'd5);
    cyc();
    dec_alu(5'd5, 5'd1, 5'd6);
    bus.hold_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      nc++; if (bus.stall !== 1'b1) begin nf++; $display("FAIL hold_stall[%0d] got %b want 1", i, bus.stall); end
      cyc();
      nc++; if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_dest !== 5'd5) begin
        nf++; $display("FAIL hold_frozen[%0d] got v%b m%b d%0d want v1 m1 d5", i, bus.ex_valid,
                       bus.ex_mem_read, bus.ex_dest); end
      nc++; if (bus.stall_count !== 4'd2) begin
        nf++; $display("FAIL hold_count[%0d] got %0d want 2", i, bus.stall_count); end
    end
    bus.hold_in = 1'b0;
    cyc();
    nc++; if (bus.ex_valid !== 1'b0 || bus.stall_count !== 4'd3) begin
      nf++; $display("FAIL hold_release got v%b c%0d want v0 c3", bus.ex_valid, bus.stall_count); end
    cyc();
    nc++; if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd6) begin
      nf++; $display("FAIL hold_issue got v%b d%0d want v1 d6", bus.ex_valid, bus.ex_dest); end
  endtask

  task automatic test_saturation();
    idle();
    dec_br(5'd9, 5'd0, 16'd0, 1'b0);
    bus.mem_mem_read = 1'b1; bus.mem_reg_write = 1'b1; bus.mem_dest = 5'd9;
    repeat (11) cyc();
    nc++; if (bus.stall_count !== 4'd14) begin nf++; $display("FAIL sat_pre got %0d want 14", bus.stall_count); end
    cyc();
    nc++; if (bus.stall_count !== 4'd15) begin nf++; $display("FAIL sat_reach got %0d want 15", bus.stall_count); end
    repeat (3) cyc();
    nc++; if (bus.stall_count !== 4'd15 || bus.stall !== 1'b1) begin
      nf++; $display("FAIL sat_hold got c%0d s%b want c15 s1", bus.stall_count, bus.stall); end
  endtask

  task automatic test_rst_mid_stall();
    rst = 1'b1;
    idle();
    #1;
    nc++; if (bus.stall_count !== 4'd0 || bus.ex_valid !== 1'b0 || bus.stall !== 1'b0) begin
      nf++; $display("FAIL rst_mid got c%0d v%b s%b want c0 v0 s0", bus.stall_count, bus.ex_valid,
                     bus.stall); end
    @(negedge clk);
    rst = 1'b0;
    dec_alu(5'd7, 5'd0, 5'd8);
    #1;
    nc++; if (bus.stall !== 1'b0) begin nf++; $display("FAIL post_rst_stall got %b want 0", bus.stall); end
    cyc();
    nc++; if (bus.ex_valid !== 1'b1 || bus.ex_rs_data !== 32'd0) begin
      nf++; $display("FAIL post_rst_rf got v%b d%h want v1 d0", bus.ex_valid, bus.ex_rs_data); end
  endtask

  task automatic test_random();
    logic [31:0] w, rsv, rtv, oa, ob;
    logic [4:0]  rs, rt, rd, wa;
    logic        wen, ha, hb, hc, br, bj, est, ered, taken;
    logic [9:0]  etgt;
    int          kind;
    rst = 1'b1;
    idle();
    #3;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    {m_v, m_rw, m_mr, m_jal, m_rs, m_rt, m_dst, m_sh} = '0;
    {m_rsd, m_rtd, m_imm, m_pc, m_ctl, m_cnt} = '0;
    for (int n = 0; n < 600; n++) begin
      clr_ctrl();
      kind = $urandom_range(0, 7);
      w = $urandom;
      w[25:21] = pick(); w[20:16] = pick(); w[15:11] = pick();
      bus.instruction = w;
      case (kind)
        0: begin bus.ctrl_reg_dst = 1'b1; bus.ctrl_reg_write = 1'b1; end
        1: begin bus.ctrl_mem_read = 1'b1; bus.ctrl_reg_write = 1'b1; end
        2: bus.ctrl_branch = 1'b1;
        3: begin bus.ctrl_branch = 1'b1; bus.ctrl_bne = 1'b1; end
        4: bus.ctrl_jump = 1'b1;
        5: begin bus.ctrl_jal = 1'b1; bus.ctrl_reg_write = 1'b1; end
        6: bus.ctrl_jr = 1'b1;
        default: ;
      endcase
      bus.ctrl_bundle   = 8'($urandom);
      bus.id_valid      = ($urandom_range(0, 9) != 0);
      bus.hold_in       = ($urandom_range(0, 7) == 0);
      bus.pc_plus1      = 10'($urandom);
      bus.mem_reg_write = 1'($urandom); bus.mem_mem_read = 1'($urandom);
      bus.mem_dest      = pick(); bus.mem_alu_res = val();
      bus.wb_we = 1'($urandom); bus.wb_jal = ($urandom_range(0, 3) == 0);
      bus.wb_dest = pick(); bus.wb_data = val();
      #2;
      rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      wa  = bus.wb_jal ? 5'd31 : bus.wb_dest;
      wen = bus.wb_we && (wa != 5'd0);
      rsv = (rs == 5'd0) ? 32'd0 : ((wen && rs == wa) ? bus.wb_data : mrf[rs]);
      rtv = (rt == 5'd0) ? 32'd0 : ((wen && rt == wa) ? bus.wb_data : mrf[rt]);
      oa = (bus.mem_reg_write && !bus.mem_mem_read && bus.mem_dest != 0 && bus.mem_dest == rs)
           ? bus.mem_alu_res : rsv;
      ob = (bus.mem_reg_write && !bus.mem_mem_read && bus.mem_dest != 0 && bus.mem_dest == rt)
           ? bus.mem_alu_res : rtv;
      br = bus.ctrl_branch;
      bj = br || bus.ctrl_jr;
      ha = bus.id_valid && m_v && m_mr && m_dst != 0 && (m_dst == rs || m_dst == rt);
      hb = bus.id_valid && bj && m_v && m_rw && m_dst != 0 && (m_dst == rs || (br && m_dst == rt));
      hc = bus.id_valid && bj && bus.mem_mem_read && bus.mem_reg_write && bus.mem_dest != 0 &&
           (bus.mem_dest == rs || (br && bus.mem_dest == rt));
      est   = bus.hold_in || ha || hb || hc;
      taken = br && ((oa == ob) != bus.ctrl_bne);
      ered  = bus.id_valid && !est && (bus.ctrl_jr || bus.ctrl_jump || bus.ctrl_jal || taken);
      if (!ered) etgt = 10'd0;
      else if (bus.ctrl_jr) etgt = 10'(oa % 1024);
      else if (bus.ctrl_jump || bus.ctrl_jal) etgt = 10'(w % 1024);
      else etgt = 10'((int'(bus.pc_plus1) + int'($signed(w[15:0]))) & 1023);
      nc++; if (bus.stall !== est) begin nf++; $display("FAIL rnd_stall[%0d] got %b want %b", n, bus.stall, est); end
      nc++; if (bus.redirect !== ered) begin
        nf++; $display("FAIL rnd_redirect[%0d] got %b want %b", n, bus.redirect, ered); end
      nc++; if (bus.redirect_target !== etgt) begin
        nf++; $display("FAIL rnd_target[%0d] got %h want %h", n, bus.redirect_target, etgt); end
      if ((ha || hb || hc) && !bus.hold_in && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
      if (!bus.hold_in) begin
        if (est || !bus.id_valid) begin
          {m_v, m_rw, m_mr, m_jal, m_rs, m_rt, m_dst, m_sh} = '0;
          {m_rsd, m_rtd, m_imm, m_pc, m_ctl} = '0;
        end else begin
          m_v = 1'b1; m_rw = bus.ctrl_reg_write; m_mr = bus.ctrl_mem_read; m_jal = bus.ctrl_jal;
          m_rs = rs; m_rt = rt; m_sh = w[10:6];
          m_dst = bus.ctrl_jal ? 5'd31 : (bus.ctrl_reg_dst ? rd : rt);
          m_rsd = rsv; m_rtd = rtv; m_imm = 32'($signed(w[15:0]));
          m_pc = bus.pc_plus1; m_ctl = bus.ctrl_bundle;
        end
      end
      if (wen) mrf[wa] = bus.wb_data;
      cyc();
      nc++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_jal} !== {m_v, m_rw, m_mr, m_jal})
        begin nf++; $display("FAIL rnd_ex_flags[%0d] got %b%b%b%b want %b%b%b%b", n, bus.ex_valid,
          bus.ex_reg_write, bus.ex_mem_read, bus.ex_jal, m_v, m_rw, m_mr, m_jal); end
      nc++; if ({bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_shamt} !== {m_rs, m_rt, m_dst, m_sh}) begin
        nf++; $display("FAIL rnd_ex_regs[%0d] got %h want %h", n,
                       {bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_shamt}, {m_rs, m_rt, m_dst, m_sh}); end
      nc++; if (bus.ex_rs_data !== m_rsd || bus.ex_rt_data !== m_rtd) begin
        nf++; $display("FAIL rnd_ex_data[%0d] got %h/%h want %h/%h", n, bus.ex_rs_data,
                       bus.ex_rt_data, m_rsd, m_rtd); end
      nc++; if ({bus.ex_imm, bus.ex_pc_plus1, bus.ex_ctrl} !== {m_imm, m_pc, m_ctl}) begin
        nf++; $display("FAIL rnd_ex_misc[%0d] got %h want %h", n,
                       {bus.ex_imm, bus.ex_pc_plus1, bus.ex_ctrl}, {m_imm, m_pc, m_ctl}); end
      nc++; if (bus.stall_count !== m_cnt) begin
        nf++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.stall_count, m_cnt); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_branch_wrap();
    test_branch_fwd();
    test_jal_jr();
    test_hold();
    test_saturation();
    test_rst_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nc, nf);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
